datreg: RTL and testbench
=========================

# datreg

Receive-side data register of the USRT. It captures a parallel byte from the receive shift logic when that logic strobes i_Enable. It holds the byte stable on o_Data for downstream consumers and emits a one-cycle o_Enable "data valid" pulse for each capture. It sits between the Rx deserializer and the host/bus interface.

## Interface
Parameters:
- DATA_WIDTH, default 8: width of the data path.

Ports:
- i_Pclk, input, 1: peripheral clock. Rising-edge active. One clock only.
- i_Reset, input, 1: reset. Asynchronous, active-high.
- i_Enable, input, 1: capture strobe, sampled on the rising edge of i_Pclk.
- i_Data, input, DATA_WIDTH: byte from the Rx deserializer.
- o_Data, output, DATA_WIDTH: registered captured byte.
- o_Enable, output, 1: data-valid pulse, registered.
- o_Parity, output, 1: even-parity bit of o_Data. Present only with DATREG_PARITY_EN.

## Operation
- Reset asserted, at any time and independent of i_Pclk:
  - o_Data, o_Enable and o_Parity go to 0 immediately.
  - They stay 0 while i_Reset is high.
- Rising edge of i_Pclk with i_Enable = 1:
  - o_Data <= i_Data.
  - o_Enable <= 1.
- Rising edge of i_Pclk with i_Enable = 0:
  - o_Data holds its last value. It is never cleared except by reset.
  - o_Enable <= 0.
- No state machine. The block is one register stage for data and one for valid.
- No backpressure or handshake. Every enabled edge overwrites o_Data, and the consumer must take the byte while o_Enable is high.
- Back-to-back strobes (i_Enable high on consecutive edges):
  - Each edge captures a new byte.
  - o_Enable stays high continuously, one cycle per captured byte.
- Changes on i_Data while i_Enable = 0 have no effect on any output.
- Reset released while i_Enable = 1: the first rising edge after release captures normally.

## Timing
- Latency is 1 cycle. The data present at edge N appears on o_Data just after edge N, and o_Enable is high from edge N to edge N+1.
- o_Enable pulse width equals the number of consecutive enabled edges times one clock period.
- All outputs are driven directly from flops, with no combinational path from the inputs.
- o_Parity is registered on the same edge as o_Data.

## Configuration
- Macro: DATREG_PARITY_EN.
- Defined:
  - Port o_Parity exists.
  - On each capture, o_Parity is registered as the XOR of all bits of i_Data (even parity).
  - o_Parity resets to 0 and holds when i_Enable = 0.
- Undefined:
  - Port o_Parity is absent and no parity logic is generated.
  - All other behaviour is identical.

## Structure
- Shared USRT package holds:
  - The DATA_WIDTH default constant (8).
  - The reset value constant for o_Data (all zeros).
- Sub-modules: a parity reducer, parity_gen, which is combinational XOR-reduce of DATA_WIDTH bits. It is instantiated only under DATREG_PARITY_EN. The rest is flat.

## Test plan
All scenarios use a 100 ns clock.
- Reset: assert i_Reset mid-cycle with o_Data = 8'hE2 -> o_Data = 0 and o_Enable = 0 immediately, without waiting for a clock edge.
- Single capture: i_Enable = 1 with i_Data = 8'b11100010 for one edge, then i_Enable = 0 and i_Data = 0 -> o_Data = 8'hE2 from that edge onward, and o_Enable high for exactly one cycle.
- Hold: after the capture above, 1111 ns idle with i_Data toggling -> o_Data stays 8'hE2 and o_Enable stays 0.
- Second capture: i_Enable pulse with i_Data = 8'b00101110 -> o_Data = 8'h2E and one o_Enable pulse. With DATREG_PARITY_EN, o_Parity = 0.
- Back-to-back: i_Enable high on three consecutive edges with i_Data = 8'h01, 8'h02, 8'h03 -> o_Data steps 01, 02, 03 and o_Enable is high for 3 cycles. With DATREG_PARITY_EN, o_Parity = 1, 1, 0.
- Reset with strobe: i_Reset released while i_Enable = 1 and i_Data = 8'hA5 -> the next edge gives o_Data = 8'hA5 and o_Enable = 1.

Source files
------------

// File: rtl/datreg_pkg.sv
// Shared USRT constants used by the receive data register.
// Holds the default data-path width and the reset value of the captured byte.
// No ports; imported with import datreg_pkg::*.
`timescale 1ns/1ps
package datreg_pkg;

  // Default width of the USRT data path.
  localparam int DATREG_DATA_WIDTH = 8;

  // Reset value of the captured data register.
  // It is kept wide so that any DATA_WIDTH up to 64 can slice it.
  localparam logic [63:0] DATREG_DATA_RST = '0;

endpackage

// File: rtl/datreg_parity_gen.sv
// parity_gen: even-parity reducer (XOR of all input bits), purely combinational.
// Latency: 0 cycles. Backpressure: none.
// Ports: i_Data [WIDTH] in, o_Parity out. Compiled only with DATREG_PARITY_EN.
`timescale 1ns/1ps
`ifdef DATREG_PARITY_EN
module parity_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_Data,
  output logic             o_Parity
);

  assign o_Parity = ^i_Data;

endmodule
`endif

// File: rtl/datreg.sv
// datreg: USRT receive data register; captures i_Data on i_Enable and pulses o_Enable.
// Latency: 1 cycle from enabled edge to o_Data/o_Enable. All outputs come straight from flops.
// Backpressure: none; every enabled edge overwrites o_Data, and the consumer takes it while o_Enable is high.
// Ports: i_Pclk clock, i_Reset async active-high, i_Enable strobe, i_Data byte in,
//        o_Data held byte, o_Enable valid pulse, o_Parity even parity (only with DATREG_PARITY_EN).
`timescale 1ns/1ps
module datreg
  import datreg_pkg::*;
#(
  parameter int DATA_WIDTH = DATREG_DATA_WIDTH
) (
  input  logic                  i_Pclk,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic                  o_Enable
`ifdef DATREG_PARITY_EN
  ,
  output logic                  o_Parity
`endif
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_enable;

  // The data register only loads on a strobe. Outside reset it is never
  // cleared, so the last byte stays visible between strobes.
  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      r_data <= DATREG_DATA_RST[DATA_WIDTH-1:0];
    end else if (i_Enable) begin
      r_data <= i_Data;
    end
  end

  // The valid flag follows the strobe with a one-cycle delay. Consecutive
  // strobes therefore keep it high, for one cycle per captured byte.
  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      r_enable <= 1'b0;
    end else begin
      r_enable <= i_Enable;
    end
  end

  assign o_Data   = r_data;
  assign o_Enable = r_enable;

`ifdef DATREG_PARITY_EN
  logic w_parity;
  logic r_parity;

  // Parity is computed on the incoming byte and registered alongside it,
  // so it never depends combinationally on the inputs.
  parity_gen #(
    .WIDTH (DATA_WIDTH)
  ) u_parity_gen (
    .i_Data   (i_Data),
    .o_Parity (w_parity)
  );

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      r_parity <= 1'b0;
    end else if (i_Enable) begin
      r_parity <= w_parity;
    end
  end

  assign o_Parity = r_parity;
`endif

endmodule

// File: tb/tb_datreg.sv
// Directed bench for datreg: reset, capture, hold, back-to-back strobes, reset release with strobe.
// 100 ns clock; inputs are driven at the falling edge or just after a rising edge, and outputs are sampled 1 ns after the rising edge.
// Parity checks are compiled in only with DATREG_PARITY_EN.
`timescale 1ns/1ps
module tb_datreg;

  logic       i_Pclk;
  logic       i_Reset;
  logic       i_Enable;
  logic [7:0] i_Data;
  logic [7:0] o_Data;
  logic       o_Enable;
`ifdef DATREG_PARITY_EN
  logic       o_Parity;
`endif

  int n_checks = 0;
  int n_errors = 0;

  datreg #(
    .DATA_WIDTH (8)
  ) dut (
    .i_Pclk   (i_Pclk),
    .i_Reset  (i_Reset),
    .i_Enable (i_Enable),
    .i_Data   (i_Data),
    .o_Data   (o_Data),
    .o_Enable (o_Enable)
`ifdef DATREG_PARITY_EN
    ,
    .o_Parity (o_Parity)
`endif
  );

  initial begin
    i_Pclk = 1'b0;
    forever #50 i_Pclk = ~i_Pclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge i_Pclk);
    #1;
  endtask

  initial begin
    i_Reset  = 1'b1;
    i_Enable = 1'b0;
    i_Data   = 8'h00;
    #1;
    check("rst_data", {24'h0, o_Data}, 32'h00);
    check("rst_en", {31'h0, o_Enable}, 32'h0);
`ifdef DATREG_PARITY_EN
    check("rst_par", {31'h0, o_Parity}, 32'h0);
`endif

    // Single capture of 8'hE2.
    @(negedge i_Pclk);
    i_Reset  = 1'b0;
    i_Enable = 1'b1;
    i_Data   = 8'b1110_0010;
    tick();
    check("cap1_data", {24'h0, o_Data}, 32'hE2);
    check("cap1_en", {31'h0, o_Enable}, 32'h1);
`ifdef DATREG_PARITY_EN
    check("cap1_par", {31'h0, o_Parity}, 32'h0);
`endif
    i_Enable = 1'b0;
    i_Data   = 8'h00;
    tick();
    check("cap1_data_hold", {24'h0, o_Data}, 32'hE2);
    check("cap1_en_drop", {31'h0, o_Enable}, 32'h0);

    // Idle for about 1100 ns while i_Data toggles. Nothing may change.
    for (int i = 0; i < 11; i++) begin
      @(negedge i_Pclk);
      i_Data = 8'(i * 37 + 1);
      tick();
      check("hold_data", {24'h0, o_Data}, 32'hE2);
      check("hold_en", {31'h0, o_Enable}, 32'h0);
    end

    // Assert reset mid-cycle. Outputs must clear without a clock edge.
    #24;
    i_Reset = 1'b1;
    #1;
    check("async_rst_data", {24'h0, o_Data}, 32'h00);
    check("async_rst_en", {31'h0, o_Enable}, 32'h0);

    // A strobe while reset is high must be ignored.
    i_Enable = 1'b1;
    i_Data   = 8'hFF;
    tick();
    check("in_rst_data", {24'h0, o_Data}, 32'h00);
    check("in_rst_en", {31'h0, o_Enable}, 32'h0);

    // Release reset with the strobe already high. The next edge captures.
    @(negedge i_Pclk);
    i_Reset = 1'b0;
    i_Data  = 8'hA5;
    tick();
    check("rel_data", {24'h0, o_Data}, 32'hA5);
    check("rel_en", {31'h0, o_Enable}, 32'h1);
`ifdef DATREG_PARITY_EN
    check("rel_par", {31'h0, o_Parity}, 32'h0);
`endif
    i_Enable = 1'b0;
    tick();
    check("rel_en_drop", {31'h0, o_Enable}, 32'h0);

    // Second capture of 8'h2E, which has even parity 0.
    @(negedge i_Pclk);
    i_Enable = 1'b1;
    i_Data   = 8'b0010_1110;
    tick();
    check("cap2_data", {24'h0, o_Data}, 32'h2E);
    check("cap2_en", {31'h0, o_Enable}, 32'h1);
`ifdef DATREG_PARITY_EN
    check("cap2_par", {31'h0, o_Parity}, 32'h0);
`endif
    i_Enable = 1'b0;
    i_Data   = 8'h00;
    tick();
    check("cap2_data_hold", {24'h0, o_Data}, 32'h2E);
    check("cap2_en_drop", {31'h0, o_Enable}, 32'h0);

    // Back-to-back strobes with 01, 02 and 03.
    @(negedge i_Pclk);
    i_Enable = 1'b1;
    i_Data   = 8'h01;
    tick();
    check("b2b1_data", {24'h0, o_Data}, 32'h01);
    check("b2b1_en", {31'h0, o_Enable}, 32'h1);
`ifdef DATREG_PARITY_EN
    check("b2b1_par", {31'h0, o_Parity}, 32'h1);
`endif
    i_Data = 8'h02;
    tick();
    check("b2b2_data", {24'h0, o_Data}, 32'h02);
    check("b2b2_en", {31'h0, o_Enable}, 32'h1);
`ifdef DATREG_PARITY_EN
    check("b2b2_par", {31'h0, o_Parity}, 32'h1);
`endif
    i_Data = 8'h03;
    tick();
    check("b2b3_data", {24'h0, o_Data}, 32'h03);
    check("b2b3_en", {31'h0, o_Enable}, 32'h1);
`ifdef DATREG_PARITY_EN
    check("b2b3_par", {31'h0, o_Parity}, 32'h0);
`endif
    i_Enable = 1'b0;
    i_Data   = 8'h7F;
    tick();
    check("b2b_end_data", {24'h0, o_Data}, 32'h03);
    check("b2b_end_en", {31'h0, o_Enable}, 32'h0);
`ifdef DATREG_PARITY_EN
    check("b2b_end_par", {31'h0, o_Parity}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
